fetch_stage: RTL and testbench

//   Instruction fetch stage; sits directly upstream of decode.
//   On each enabled pulse it chooses the next PC (sequential or redirected), reads one
//   32-bit word from a synchronous instruction BRAM, and presents pc/instr_raw to decode.
//   It signals completion with the same enabled/completed handshake that decode uses.

---
 rtl/fetch_stage.sv | 96 +++++++++
 tb/tb_fetch_stage.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: selects the next PC, reads one word from a synchronous
// instruction BRAM and hands pc/instr_raw to decode with an enabled/completed handshake.
module fetch_stage #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          ADDR_WIDTH  = 15,
  parameter int          MEM_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  enabled,
  input  logic                  jump_en,
  input  logic [31:0]           jump_pc,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [31:0]           imem_rdata,
  output logic                  completed,
  output logic [31:0]           pc,
  output logic [31:0]           instr_raw,
  output logic                  misaligned
);

  localparam int              CW       = $clog2(MEM_LATENCY + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(MEM_LATENCY);
  localparam logic [31:0]     NOP      = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                  state_q;
  logic [CW-1:0]           cnt_q;
  logic [31:0]             pc_q;
  logic [31:0]             npc_q;
  logic [31:0]             npc_d;
  logic [31:0]             instr_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    mis_q;
  logic                    first_q;

  // Next-PC select: a redirect beats the post-reset first fetch, which beats pc+4.
  always_comb begin
    npc_d = pc_q + 32'd4;
    if (jump_en) begin
      npc_d = {jump_pc[31:2], 2'b00};
    end else if (first_q) begin
      npc_d = RESET_PC;
    end else begin
      npc_d = pc_q + 32'd4;
    end
  end

  // Fetch FSM; rdata is valid one cycle after the BRAM's own latency, hence capture at cnt==MEM_LATENCY.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pc_q    <= RESET_PC;
      npc_q   <= RESET_PC;
      instr_q <= NOP;
      addr_q  <= RESET_PC[ADDR_WIDTH+1:2];
      mis_q   <= 1'b0;
      first_q <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (enabled) begin
            npc_q   <= npc_d;
            addr_q  <= npc_d[ADDR_WIDTH+1:2];
            mis_q   <= jump_en & (|jump_pc[1:0]);
            first_q <= 1'b0;
            cnt_q   <= '0;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt_q == CNT_LAST) begin
            instr_q <= imem_rdata;
            pc_q    <= npc_q;
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign completed  = (state_q == S_DONE) & ~enabled;
  assign pc         = pc_q;
  assign instr_raw  = instr_q;
  assign imem_addr  = addr_q;
  assign misaligned = mis_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: two instances (MEM_LATENCY 2 and 1) share stimulus,
// each with its own BRAM model and completion monitor.
module tb_fetch_stage;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        mis;
    logic [14:0] addr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        enabled = 1'b0;
  logic        jump_en = 1'b0;
  logic [31:0] jump_pc = 32'h0;

  logic [14:0] addr2, addr1;
  logic [31:0] rdata2, rdata1;
  logic        comp2, comp1;
  logic [31:0] pc2, pc1, ir2, ir1;
  logic        mis2, mis1;

  logic [31:0] mem [0:255];
  logic [31:0] s2a, s2b, s1a;

  exp_t q2[$];
  exp_t q1[$];
  exp_t e2, e1;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int e0 = 0;
  int done2 = 0;
  int done1 = 0;
  logic c2_prev = 1'b0;
  logic c1_prev = 1'b0;

  fetch_stage #(.MEM_LATENCY(2)) u_l2 (
    .clk(clk), .rstn(rstn), .enabled(enabled), .jump_en(jump_en), .jump_pc(jump_pc),
    .imem_addr(addr2), .imem_rdata(rdata2), .completed(comp2), .pc(pc2),
    .instr_raw(ir2), .misaligned(mis2)
  );

  fetch_stage #(.MEM_LATENCY(1)) u_l1 (
    .clk(clk), .rstn(rstn), .enabled(enabled), .jump_en(jump_en), .jump_pc(jump_pc),
    .imem_addr(addr1), .imem_rdata(rdata1), .completed(comp1), .pc(pc1),
    .instr_raw(ir1), .misaligned(mis1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // BRAM models with the read latency each instance is configured for.
  always @(posedge clk) begin
    s2a <= mem[addr2[7:0]];
    s2b <= s2a;
    s1a <= mem[addr1[7:0]];
  end
  assign rdata2 = s2b;
  assign rdata1 = s1a;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (comp2 && !c2_prev) begin
      if (q2.size() == 0) begin
        checks = checks + 1;
        failures = failures + 1;
        $display("FAIL unexpected_done_L2 actual=completion expected=none pc=%h", pc2);
      end else begin
        e2 = q2.pop_front();
        chk("pc_L2", pc2, e2.pc);
        chk("instr_L2", ir2, e2.instr);
        chk("mis_L2", {31'd0, mis2}, {31'd0, e2.mis});
        chk("addr_L2", {17'd0, addr2}, {17'd0, e2.addr});
        chk("latency_L2", 32'(cyc - e0), 32'd3);
        done2 = done2 + 1;
      end
    end
    c2_prev <= comp2;
  end

  always @(negedge clk) begin
    if (comp1 && !c1_prev) begin
      if (q1.size() == 0) begin
        checks = checks + 1;
        failures = failures + 1;
        $display("FAIL unexpected_done_L1 actual=completion expected=none pc=%h", pc1);
      end else begin
        e1 = q1.pop_front();
        chk("pc_L1", pc1, e1.pc);
        chk("instr_L1", ir1, e1.instr);
        chk("mis_L1", {31'd0, mis1}, {31'd0, e1.mis});
        chk("addr_L1", {17'd0, addr1}, {17'd0, e1.addr});
        chk("latency_L1", 32'(cyc - e0), 32'd2);
        done1 = done1 + 1;
      end
    end
    c1_prev <= comp1;
  end

  task automatic fetch(input logic jen, input logic [31:0] jpc, input logic [31:0] epc,
                       input logic [31:0] eir, input logic emis, input logic [14:0] eaddr,
                       input bit extra);
    exp_t e;
    int   d1;
    int   d2;
    bit   ok;
    e.pc = epc; e.instr = eir; e.mis = emis; e.addr = eaddr;
    q2.push_back(e);
    q1.push_back(e);
    d1 = done1;
    d2 = done2;
    @(negedge clk);
    enabled = 1'b1; jump_en = jen; jump_pc = jpc; e0 = cyc + 1;
    #1;
    chk("completed_drop_L2", {31'd0, comp2}, 32'd0);
    chk("completed_drop_L1", {31'd0, comp1}, 32'd0);
    @(negedge clk);
    jump_en = 1'b0; jump_pc = 32'hDEAD_BEEF;
    if (extra) begin
      @(negedge clk);
    end
    enabled = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      #1;
      if (done1 > d1 && done2 > d2) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks = checks + 1;
      failures = failures + 1;
      $display("FAIL fetch_timeout actual=done1:%0d,done2:%0d expected=completion pc=%h", done1, done2, epc);
    end
    @(negedge clk);
    #1;
    chk("completed_level_L2", {31'd0, comp2}, 32'd1);
    chk("completed_level_L1", {31'd0, comp1}, 32'd1);
  endtask

  task automatic check_reset_state(input string tag);
    chk({"rst_completed_L2_", tag}, {31'd0, comp2}, 32'd0);
    chk({"rst_completed_L1_", tag}, {31'd0, comp1}, 32'd0);
    chk({"rst_pc_L2_", tag}, pc2, 32'd0);
    chk({"rst_pc_L1_", tag}, pc1, 32'd0);
    chk({"rst_instr_L2_", tag}, ir2, 32'h0000_0013);
    chk({"rst_instr_L1_", tag}, ir1, 32'h0000_0013);
    chk({"rst_addr_L2_", tag}, {17'd0, addr2}, 32'd0);
    chk({"rst_addr_L1_", tag}, {17'd0, addr1}, 32'd0);
    chk({"rst_mis_L2_", tag}, {31'd0, mis2}, 32'd0);
    chk({"rst_mis_L1_", tag}, {31'd0, mis1}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 | i;
    mem[0] = 32'h0050_0093;
    mem[1] = 32'h0010_0113;
    mem[2] = 32'h0020_81B3;
    mem[3] = 32'h4011_0233;

    repeat (3) @(negedge clk);
    #1;
    check_reset_state("initial");
    rstn = 1'b1;
    @(negedge clk);

    fetch(1'b0, 32'h0, 32'h0000_0000, 32'h0050_0093, 1'b0, 15'd0, 1'b0);
    fetch(1'b0, 32'h0, 32'h0000_0004, 32'h0010_0113, 1'b0, 15'd1, 1'b0);
    fetch(1'b0, 32'h0, 32'h0000_0008, 32'h0020_81B3, 1'b0, 15'd2, 1'b0);
    fetch(1'b0, 32'h0, 32'h0000_000C, 32'h4011_0233, 1'b0, 15'd3, 1'b0);
    fetch(1'b1, 32'h0000_0102, 32'h0000_0100, 32'hA500_0040, 1'b1, 15'h40, 1'b0);
    fetch(1'b0, 32'h0, 32'h0000_0104, 32'hA500_0041, 1'b0, 15'h41, 1'b0);
    // enabled held into WAIT: the second sample must be ignored
    fetch(1'b0, 32'h0, 32'h0000_0108, 32'hA500_0042, 1'b0, 15'h42, 1'b1);

    // Reset during WAIT aborts the fetch.
    @(negedge clk);
    enabled = 1'b1; jump_en = 1'b0;
    @(negedge clk);
    enabled = 1'b0; rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      #1;
      chk("abort_completed_L2", {31'd0, comp2}, 32'd0);
      chk("abort_completed_L1", {31'd0, comp1}, 32'd0);
    end
    check_reset_state("abort");

    fetch(1'b0, 32'h0, 32'h0000_0000, 32'h0050_0093, 1'b0, 15'd0, 1'b0);
    fetch(1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'hA500_00FF, 1'b0, 15'h7FFF, 1'b0);
    fetch(1'b0, 32'h0, 32'h0000_0000, 32'h0050_0093, 1'b0, 15'd0, 1'b0);

    repeat (5) @(negedge clk);
    #1;
    chk("queue_empty_L2", 32'(q2.size()), 32'd0);
    chk("queue_empty_L1", 32'(q1.size()), 32'd0);
    chk("done_count_L2", 32'(done2), 32'd10);
    chk("done_count_L1", 32'(done1), 32'd10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
